// File: rtl/sim_pkg.sv
// Shared simulation-harness definitions: dump FSM states and memory constants.
package sim_pkg;

    typedef enum logic [2:0] {
        RUN   = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        EMIT  = 3'd3,
        DONE  = 3'd4
    } dump_state_t;

    localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h8000_1000;
    localparam int          WORD_BYTES          = 4;

endpackage

// File: rtl/signature_dumper_if.sv
// Bundle of snoop, dump-port and signature-stream signals between the dumper and the harness.
interface signature_dumper_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Stream handshake: a word transfers on every clock edge where sig_valid and
    // sig_ready are both high; while sig_valid is high and sig_ready low, sig_data
    // is held and sig_valid stays asserted until the transfer happens.
    logic [ADDR_W-1:0] sig_begin;
    logic [ADDR_W-1:0] sig_end;
    logic              snoop_we;
    logic [ADDR_W-1:0] snoop_addr;
    logic [DATA_W-1:0] snoop_wdata;
    logic              core_halt;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              sig_valid;
    logic [DATA_W-1:0] sig_data;
    logic              sig_ready;
    logic [DATA_W-2:0] exit_code;
    logic              done;

    modport master (
        input  sig_begin, sig_end, snoop_we, snoop_addr, snoop_wdata, mem_rdata, sig_ready,
        output core_halt, mem_re, mem_addr, sig_valid, sig_data, exit_code, done
    );

    modport slave (
        output sig_begin, sig_end, snoop_we, snoop_addr, snoop_wdata, mem_rdata, sig_ready,
        input  core_halt, mem_re, mem_addr, sig_valid, sig_data, exit_code, done
    );
endinterface

// File: rtl/signature_dumper.sv
// Detects the tohost halt store, stalls the core and streams the [sig_begin, sig_end)
// signature window out of data memory one word at a time.
module signature_dumper
    import sim_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(TOHOST_ADDR_DEFAULT)
) (
    input  logic                clk,
    input  logic                reset,
    signature_dumper_if.master  bus,
    output dump_state_t         o_dbg_state
);

    dump_state_t       r_state;
    dump_state_t       w_next_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [DATA_W-1:0] r_sig_data;
    logic [DATA_W-2:0] r_exit_code;
    logic              w_halt_store;
    logic [ADDR_W-1:0] w_ptr_next;

    assign w_halt_store = bus.snoop_we && (bus.snoop_addr == TOHOST_ADDR) && bus.snoop_wdata[0];
    assign w_ptr_next   = r_ptr + ADDR_W'(WORD_BYTES);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RUN: begin
                if (w_halt_store) begin
                    w_next_state = (bus.sig_begin == bus.sig_end) ? DONE : FETCH;
                end
            end
            FETCH: w_next_state = LATCH;
            LATCH: w_next_state = EMIT;
            EMIT: begin
                if (bus.sig_ready) begin
                    w_next_state = (w_ptr_next == bus.sig_end) ? DONE : FETCH;
                end
            end
            DONE:    w_next_state = DONE;
            default: w_next_state = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= RUN;
            r_ptr       <= '0;
            r_sig_data  <= '0;
            r_exit_code <= '0;
        end else begin
            r_state <= w_next_state;
            // Only the first halt store is honoured; later ones arrive outside RUN.
            if (r_state == RUN && w_halt_store) begin
                r_ptr       <= bus.sig_begin;
                r_exit_code <= bus.snoop_wdata[DATA_W-1:1];
            end
            if (r_state == LATCH) begin
                r_sig_data <= bus.mem_rdata;
            end
            if (r_state == EMIT && bus.sig_ready) begin
                r_ptr <= w_ptr_next;
            end
        end
    end

    // Every output is a register or a decode of r_state, so no input reaches an output combinationally.
    assign bus.core_halt = (r_state != RUN);
    assign bus.mem_re    = (r_state == FETCH);
    assign bus.mem_addr  = r_ptr;
    assign bus.sig_valid = (r_state == EMIT);
    assign bus.sig_data  = r_sig_data;
    assign bus.exit_code = r_exit_code;
    assign bus.done      = (r_state == DONE);
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_signature_dumper.sv
// Bench for signature_dumper: store-decode table, directed dump sequences and randomized dumps.
module tb_signature_dumper;
    import sim_pkg::*;

    localparam logic [31:0] TOHOST = 32'h8000_1000;

    logic        clk;
    logic        reset;
    dump_state_t dbg_state;

    signature_dumper_if #(.ADDR_W(32), .DATA_W(32)) bus();

    signature_dumper #(.ADDR_W(32), .DATA_W(32), .TOHOST_ADDR(TOHOST)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .o_dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- memory model ----------------
    logic [31:0] ram [logic [31:0]];

    always @(posedge clk) begin
        if (bus.mem_re) begin
            bus.mem_rdata <= ram.exists(bus.mem_addr) ? ram[bus.mem_addr] : 32'hDEAD_BEEF;
        end
    end

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    int          hs_cnt, mem_re_cnt, valid_cnt;
    logic        prev_valid, prev_ready, prev_re;
    logic [31:0] prev_data;
    logic [31:0] exp_word;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            prev_re    = 1'b0;
        end else begin
            if (bus.mem_re) begin
                mem_re_cnt++;
                check("mem_re_back_to_back", {31'd0, prev_re}, 32'd0);
            end
            if (prev_valid && !prev_ready) begin
                check("stall_valid_hold", {31'd0, bus.sig_valid}, 32'd1);
                check("stall_data_hold", bus.sig_data, prev_data);
            end
            if (bus.sig_valid) valid_cnt++;
            if (bus.sig_valid && bus.sig_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    check("extra_word", bus.sig_data, 32'hxxxx_xxxx);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("stream_word", bus.sig_data, exp_word);
                end
            end
            prev_valid = bus.sig_valid;
            prev_ready = bus.sig_ready;
            prev_re    = bus.mem_re;
            prev_data  = bus.sig_data;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        exp_q.delete();
        hs_cnt     = 0;
        mem_re_cnt = 0;
        valid_cnt  = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_core_halt"}, {31'd0, bus.core_halt}, 32'd0);
        check({tag, "_mem_re"},    {31'd0, bus.mem_re},    32'd0);
        check({tag, "_mem_addr"},  bus.mem_addr,           32'd0);
        check({tag, "_sig_valid"}, {31'd0, bus.sig_valid}, 32'd0);
        check({tag, "_sig_data"},  bus.sig_data,           32'd0);
        check({tag, "_exit_code"}, {1'b0, bus.exit_code},  32'd0);
        check({tag, "_done"},      {31'd0, bus.done},      32'd0);
        check({tag, "_state_run"}, {31'd0, dbg_state == RUN}, 32'd1);
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.snoop_we  = 1'b0;
        bus.sig_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        clear_counts();
    endtask

    // Reference: the dump stream is simply the RAM words at begin, begin+4, ... below end.
    task automatic setup_window(input logic [31:0] b, input int n, input bit rnd);
        bus.sig_begin = b;
        bus.sig_end   = b + 32'(4 * n);
        for (int i = 0; i < n; i++) begin
            ram[b + 32'(4 * i)] = rnd ? $urandom : 32'(17 * (i + 1));
            exp_q.push_back(ram[b + 32'(4 * i)]);
        end
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        bus.snoop_we    = 1'b1;
        bus.snoop_addr  = addr;
        bus.snoop_wdata = data;
        tick();
        bus.snoop_we = 1'b0;
    endtask

    // mode 0: ready high, 1: random ready, 2: ready low 5 cycles per word.
    task automatic run_dump(input int mode, input int inj_cycle);
        int stall;
        stall = 0;
        for (int c = 0; c < 600 && !bus.done; c++) begin
            case (mode)
                0: bus.sig_ready = 1'b1;
                1: bus.sig_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (bus.sig_valid && stall == 5) begin
                        bus.sig_ready = 1'b1;
                        stall = 0;
                    end else begin
                        bus.sig_ready = 1'b0;
                        if (bus.sig_valid) stall++;
                    end
                end
            endcase
            bus.snoop_we    = (c == inj_cycle);
            bus.snoop_addr  = TOHOST;
            bus.snoop_wdata = 32'hFF;
            tick();
        end
        bus.snoop_we  = 1'b0;
        bus.sig_ready = 1'b0;
        check("dump_finished", {31'd0, bus.done}, 32'd1);
    endtask

    task automatic wait_valid(input string name);
        for (int c = 0; c < 20 && !bus.sig_valid; c++) tick();
        check(name, {31'd0, bus.sig_valid}, 32'd1);
    endtask

    // ---------------- store-decode table ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_halt;
        logic [31:0] exp_exit;
    } store_vec_t;

    store_vec_t vecs[10];

    initial begin
        logic [31:0] code;
        int          n;

        vecs[0] = '{TOHOST,          32'h0000_0000, 1'b0, 32'h0};
        vecs[1] = '{TOHOST + 32'd4,  32'h0000_0001, 1'b0, 32'h0};
        vecs[2] = '{TOHOST - 32'd4,  32'h0000_0001, 1'b0, 32'h0};
        vecs[3] = '{TOHOST,          32'hFFFF_FFFE, 1'b0, 32'h0};
        vecs[4] = '{32'h0000_0000,   32'h0000_0001, 1'b0, 32'h0};
        vecs[5] = '{TOHOST,          32'h0000_0001, 1'b1, 32'h0};
        vecs[6] = '{TOHOST,          32'h0000_0007, 1'b1, 32'h3};
        vecs[7] = '{TOHOST,          32'hFFFF_FFFF, 1'b1, 32'h7FFF_FFFF};
        vecs[8] = '{TOHOST,          32'h0000_0100, 1'b0, 32'h0};
        vecs[9] = '{TOHOST,          32'hA5A5_0001, 1'b1, 32'h52D2_8000};

        reset           = 1'b1;
        bus.snoop_we    = 1'b0;
        bus.snoop_addr  = '0;
        bus.snoop_wdata = '0;
        bus.sig_ready   = 1'b0;
        bus.sig_begin   = 32'h2000;
        bus.sig_end     = 32'h2000;
        do_reset();
        check_all_zero("reset");

        foreach (vecs[i]) begin
            do_reset();
            bus.sig_begin = 32'h2000;
            bus.sig_end   = 32'h2000;
            store(vecs[i].addr, vecs[i].wdata);
            check("tbl_core_halt", {31'd0, bus.core_halt}, {31'd0, vecs[i].exp_halt});
            check("tbl_left_run", {31'd0, dbg_state != RUN}, {31'd0, vecs[i].exp_halt});
            check("tbl_exit_code", {1'b0, bus.exit_code}, vecs[i].exp_exit);
        end

        // Basic dump with exact cycle timing.
        do_reset();
        setup_window(32'h2000, 3, 1'b0);
        bus.sig_ready = 1'b1;
        store(TOHOST, 32'h1);
        check("t1_halt_n1", {31'd0, bus.core_halt}, 32'd1);
        check("t1_mem_re_n1", {31'd0, bus.mem_re}, 32'd1);
        tick();
        check("t1_valid_n2", {31'd0, bus.sig_valid}, 32'd0);
        tick();
        check("t1_valid_n3", {31'd0, bus.sig_valid}, 32'd1);
        check("t1_data_n3", bus.sig_data, 32'h11);
        for (int i = 0; i < 6; i++) tick();
        check("t1_valid_n9", {31'd0, bus.sig_valid}, 32'd1);
        check("t1_data_n9", bus.sig_data, 32'h33);
        tick();
        check("t1_done_n10", {31'd0, bus.done}, 32'd1);
        check("t1_halt_sticky", {31'd0, bus.core_halt}, 32'd1);
        check("t1_exit_code", {1'b0, bus.exit_code}, 32'd0);
        check("t1_words", 32'(hs_cnt), 32'd3);
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
        bus.sig_ready = 1'b0;

        // Backpressure.
        do_reset();
        setup_window(32'h2000, 3, 1'b0);
        store(TOHOST, 32'h1);
        run_dump(2, -1);
        check("bp_words", 32'(hs_cnt), 32'd3);
        check("bp_mem_re", 32'(mem_re_cnt), 32'd3);
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Empty window.
        do_reset();
        setup_window(32'h2000, 0, 1'b0);
        bus.sig_ready = 1'b1;
        store(TOHOST, 32'h7);
        check("empty_done", {31'd0, bus.done}, 32'd1);
        check("empty_exit", {1'b0, bus.exit_code}, 32'd3);
        for (int i = 0; i < 5; i++) tick();
        check("empty_no_valid", 32'(valid_cnt), 32'd0);
        check("empty_no_mem_re", 32'(mem_re_cnt), 32'd0);
        bus.sig_ready = 1'b0;

        // Non-halt stores, then the real halt.
        do_reset();
        setup_window(32'h2000, 3, 1'b0);
        store(TOHOST, 32'h0);
        check("nh_halt_a", {31'd0, bus.core_halt}, 32'd0);
        check("nh_state_a", {31'd0, dbg_state == RUN}, 32'd1);
        store(TOHOST + 32'd4, 32'h1);
        check("nh_halt_b", {31'd0, bus.core_halt}, 32'd0);
        check("nh_state_b", {31'd0, dbg_state == RUN}, 32'd1);
        store(TOHOST, 32'h1);
        check("nh_trigger", {31'd0, bus.core_halt}, 32'd1);
        run_dump(0, -1);
        check("nh_words", 32'(hs_cnt), 32'd3);

        // Reset during EMIT of the second word.
        do_reset();
        setup_window(32'h2000, 3, 1'b0);
        store(TOHOST, 32'h1);
        wait_valid("rst_word1_valid");
        bus.sig_ready = 1'b1;
        tick();
        bus.sig_ready = 1'b0;
        wait_valid("rst_word2_valid");
        check("rst_word2_data", bus.sig_data, 32'h22);
        reset = 1'b1;
        tick();
        check_all_zero("mid_reset");
        reset = 1'b0;
        clear_counts();
        setup_window(32'h2000, 3, 1'b0);
        store(TOHOST, 32'h1);
        run_dump(0, -1);
        check("rst_restart_words", 32'(hs_cnt), 32'd3);
        check("rst_restart_queue", 32'(exp_q.size()), 32'd0);

        // Second halt store while dumping.
        do_reset();
        setup_window(32'h2000, 3, 1'b0);
        store(TOHOST, 32'h5);
        run_dump(1, 2);
        check("second_halt_exit", {1'b0, bus.exit_code}, 32'd2);
        check("second_halt_words", 32'(hs_cnt), 32'd3);
        check("second_halt_queue", 32'(exp_q.size()), 32'd0);

        // Randomized dumps.
        for (int it = 0; it < 20; it++) begin
            do_reset();
            n = $urandom_range(0, 5);
            setup_window(32'h3000 + 32'(4 * $urandom_range(0, 15)), n, 1'b1);
            for (int k = 0; k < 3; k++) begin
                code = $urandom;
                if ($urandom_range(0, 1) == 0) store(TOHOST, code & 32'hFFFF_FFFE);
                else store(TOHOST + 32'(4 * $urandom_range(1, 8)), code | 32'h1);
            end
            check("rnd_noise_no_halt", {31'd0, bus.core_halt}, 32'd0);
            code = $urandom | 32'h1;
            store(TOHOST, code);
            run_dump(1, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 10)) : -1);
            check("rnd_exit", {1'b0, bus.exit_code}, code >> 1);
            check("rnd_words", 32'(hs_cnt), 32'(n));
            check("rnd_mem_re", 32'(mem_re_cnt), 32'(n));
            check("rnd_queue_empty", 32'(exp_q.size()), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/signature_dumper.md
# signature_dumper

Simulation-side reader that ends a compliance-test run and streams the result signature out of data memory. It watches the core's data-memory write port for a halt store to the `tohost` address and then stalls the core. It reads every word in the `[sig_begin, sig_end)` window through a dedicated memory read port and hands each word to the bench over a valid/ready stream. The block sits beside `top` in the test harness and is the output-side counterpart of the hex-file memory preload.

## Interface
- `TOHOST_ADDR`, default 32'h8000_1000: byte address whose store with `wdata[0]=1` signals halt.
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: word width; fixed at 32 for this core.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset; one clock domain only.
- `sig_begin`  in  ADDR_W  first signature byte address; word-aligned; stable after reset.
- `sig_end`  in  ADDR_W  exclusive end byte address; word-aligned; `sig_end >= sig_begin`.
- `snoop_we`  in  1  core data-memory write strobe.
- `snoop_addr`  in  ADDR_W  core write address.
- `snoop_wdata`  in  DATA_W  core write data.
- `core_halt`  out  1  stalls the core and freezes its memory port; sticky until reset.
- `mem_re`  out  1  read strobe to the data-memory dump port.
- `mem_addr`  out  ADDR_W  read byte address.
- `mem_rdata`  in  DATA_W  read data; synchronous RAM, valid the cycle after `mem_re`.
- `sig_valid`  out  1  signature word available.
- `sig_data`  out  DATA_W  signature word.
- `sig_ready`  in  1  bench accepts the word.
- `exit_code`  out  DATA_W-1  `snoop_wdata[31:1]` captured on the halt store.
- `done`  out  1  all words emitted; sticky until reset.

## Operation
- States:
  - RUN: idle, snooping.
  - FETCH: `mem_re=1`, `mem_addr=ptr`.
  - LATCH: `mem_rdata` is registered into `sig_data`.
  - EMIT: `sig_valid=1`.
  - DONE.
- RUN → FETCH when `snoop_we && snoop_addr==TOHOST_ADDR && snoop_wdata[0]`.
  - On that transition: `ptr<=sig_begin`, `exit_code<=snoop_wdata[31:1]`, `core_halt<=1`.
- RUN → DONE directly when the halt store is seen and `sig_begin==sig_end`. `exit_code` is still captured.
- FETCH → LATCH unconditionally.
- LATCH → EMIT unconditionally.
- EMIT: `sig_data` and `sig_valid` are held stable while `sig_ready=0`.
  - On `sig_ready=1`: `ptr<=ptr+4`.
  - If `ptr+4==sig_end`, go to DONE; otherwise go to FETCH.
- DONE: `done=1`, `core_halt=1`. No further reads or stream activity.
- Ignored stores (no effect):
  - Stores to `TOHOST_ADDR` with `wdata[0]=0`.
  - Stores to any other address.
  - Any store outside RUN. A second halt store is ignored.
- `ptr[1:0]` is always 0. Address arithmetic is modulo 2^ADDR_W; no wrap handling beyond that.

## Timing
- Reset values: `core_halt=0`, `mem_re=0`, `mem_addr=0`, `sig_valid=0`, `sig_data=0`, `exit_code=0`, `done=0`; state RUN.
- Halt store sampled in cycle N:
  - `core_halt=1` and `mem_re=1` in cycle N+1.
  - `sig_valid=1` in cycle N+3.
- Per-word minimum is 3 cycles (FETCH, LATCH, EMIT) with `sig_ready` tied high.
- Last word accepted in cycle M → `done=1` in cycle M+1.
- `mem_re` is high only in FETCH and never two cycles in a row.
- All outputs are registered or decoded directly from the state register. No combinational path from `sig_ready` or snoop inputs to any output.
- `reset` mid-operation, in any state, returns to RUN on the next edge and clears every output. An in-flight `mem_rdata` is discarded.

## Structure
- Shared simulation package `sim_pkg` holds:
  - the state enum `dump_state_t` (RUN, FETCH, LATCH, EMIT, DONE);
  - the `TOHOST_ADDR` default constant;
  - the `WORD_BYTES=4` constant.
- Single module, no sub-modules; the FSM and the pointer/data registers live together.
- The harness wires `snoop_*` to the core data port and `mem_*` to a second read port of the data RAM.

## Test plan
- Halt with a window: `sig_begin=0x2000`, `sig_end=0x200C`, RAM holds 0x11, 0x22, 0x33; store 0x1 to `TOHOST_ADDR`; `sig_ready=1`.
  - Expect stream 0x11, 0x22, 0x33, then `done`.
  - First `sig_valid` 3 cycles after the store; `exit_code=0`.
- Backpressure: same window, `sig_ready` low for 5 cycles per word.
  - `sig_data` stable while stalled; exactly 3 handshakes; no extra `mem_re`.
- Empty window: `sig_begin=sig_end=0x2000`; store 0x7.
  - `done=1` next cycle, `exit_code=3`, `sig_valid` never asserted, `mem_re` never asserted.
- Non-halt stores: store 0x0 to `TOHOST_ADDR`, then 0x1 to `TOHOST_ADDR+4`.
  - `core_halt` stays 0 and state stays RUN.
  - A following store of 0x1 to `TOHOST_ADDR` triggers the dump.
- Reset mid-dump: assert `reset` during EMIT of word 2.
  - All outputs 0 the next cycle.
  - A new halt store restarts the dump from `sig_begin` and emits all 3 words.
- Second halt store during the dump (0xFF): `exit_code` keeps its first value and `ptr` is unaffected.
